pipelined_prefix_adder: RTL and testbench
=========================================

Name: pipelined_prefix_adder

Overview:
- Parametrised, pipelined successor to the team's fixed 8-bit combinational parallel-prefix adder.
- Built from the same cell set: generate/propagate (square), prefix combine (big circle), sum xor (triangle).
- Adds configurable width, selectable prefix topology, pipeline registers every STAGE_LEVELS prefix levels, carry-in, subtract mode, status flags and a valid/ready stream interface.
- Sits in datapaths that need a wide adder at high clock rates with backpressure.

Parameters:
- WIDTH, 32, operand/sum width; legal range 2..128.
- STAGE_LEVELS, 2, prefix levels per pipeline stage; legal range 1..L, where L = clog2(WIDTH).
- TOPOLOGY, 0, prefix network: 0 = Kogge-Stone, 1 = Sklansky.
- TAG_W, 4, width of the sideband tag carried alongside each operation; legal range 1..16.

Ports:
- clk, input, 1, single clock; rising edge.
- rst_n, input, 1, reset; asynchronous assert, active-low.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, adder accepts a beat this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry-in; ignored when sub=1.
- sub, input, 1, 1 = compute a - b.
- tag_in, input, TAG_W, sideband tag returned unchanged with the result.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- sum, output, WIDTH, result.
- cout, output, 1, carry out of the MSB; for subtraction 1 = no borrow.
- ovf, output, 1, signed overflow.
- zero, output, 1, sum == 0.
- tag_out, output, TAG_W, tag of the current result.

Behaviour:
- Reset: async on rst_n=0. All valid bits, sum, cout, ovf, zero and tag_out are 0. in_ready is 1 while in reset and after release.
- Operand prep (combinational, stage 0):
  - b_eff = b ^ {WIDTH{sub}}.
  - c_in = sub ? 1 : cin.
  - g[i] = a[i] & b_eff[i]; p[i] = a[i] ^ b_eff[i].
  - c_in is folded into bit 0: g[0] |= p[0] & c_in.
- Prefix network:
  - L = clog2(WIDTH) levels, grouped into NS = ceil(L / STAGE_LEVELS) stages.
  - Kogge-Stone, level k: node i >= 2^k combines with node i - 2^k.
  - Sklansky, level k: node i with bit k of i set combines with the top node of the lower half-block.
  - Nodes that do not combine pass through unchanged.
  - A pipeline register follows every group except the last. The last group, sum xor and flag logic feed the output register directly.
- Latency: exactly NS cycles from an accepted beat to out_valid. For the defaults (L=5, SL=2) NS = 3; for SL >= L, NS = 1.
- Result:
  - sum[i] = p[i] ^ carry[i-1], with carry[-1] = c_in.
  - cout = G[WIDTH-1:0].
  - ovf = carry into MSB ^ cout.
  - zero = ~|sum.
- Pipeline payload: the original p vector, tag and c_in travel with g/p through every stage.
- Handshake:
  - Global advance enable: adv = out_ready | ~out_valid; in_ready = adv.
  - When adv = 0, every stage register holds, including valid bits and payload.
  - When adv = 1, each stage loads from its predecessor, and stage 1 loads {in_valid, data}.
  - Internal bubbles propagate; they do not collapse.
- Ordering: strictly in order. No beat is dropped or duplicated.
- Stall: while out_valid=1 and out_ready=0, sum, flags and tag_out hold stable.
- Simultaneous input accept and output drain in the same cycle are both legal.
- Reset mid-operation: all in-flight beats are discarded. No stale out_valid appears after rst_n deasserts.
- Width rule: internal carries are WIDTH bits; there is no extension beyond cout.

Decomposition:
- Shared package prefix_pkg:
  - clog2 function.
  - TOPO_KOGGE_STONE / TOPO_SKLANSKY localparams.
  - Function returning the partner index for (topology, level, node), or -1 for pass-through.
- Sub-module prefix_level:
  - One combinational prefix level (WIDTH big-circle or pass-through nodes), parameterised by WIDTH, TOPOLOGY and LEVEL.
  - The top level instantiates L of them and inserts stage registers between groups.

Test Plan:
- Reset: rst_n low for 3 cycles with in_valid=1 -> out_valid=0, sum=0, in_ready=1. After release, the first beat's result appears exactly NS=3 cycles after acceptance.
- Carry ripple, defaults: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 3 cycles sum=0x00000000, cout=1, zero=1, ovf=0.
- Subtract overflow: a=0x80000000, b=0x00000001, sub=1, tag=0xA -> sum=0x7FFFFFFF, cout=1, ovf=1, zero=0, tag_out=0xA.
- Backpressure: 8 back-to-back beats (a=i, b=i, tag=i), with out_ready=0 for 5 cycles after the first result:
  - in_ready=0 and outputs stable throughout the stall.
  - Results 0, 2, 4, ... 14 emerge in order with matching tags.
- Reset mid-flight: pulse rst_n low for 1 cycle while 3 beats are in flight -> out_valid stays 0 afterwards until new beats complete; none of the old results ever appear.
- Random sweep vs golden model: WIDTH in {8, 32, 64}, STAGE_LEVELS in {1, 2, L}, both topologies, random in_valid/out_ready -> sum, cout, ovf, zero and tag match the model, and the latency equals NS.

Source files
------------

// File: rtl/prefix_pkg.sv
// Shared helpers for the parallel-prefix adder: log2, topology ids, wiring rule.
// Latency: none; constants and elaboration-time functions only.
// Backpressure: not applicable.
package prefix_pkg;

  localparam int TOPO_KOGGE_STONE = 0;
  localparam int TOPO_SKLANSKY    = 1;

  // Smallest n with 2**n >= value; used to size the prefix network.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Node that 'node' combines with at prefix 'level', or -1 when it passes through.
  // Kogge-Stone looks back by 2**level; Sklansky reaches to the top node of the
  // lower half of its 2**(level+1) block.
  function automatic int prefix_partner(input int topology, input int level, input int node);
    int span;
    span = 1 << level;
    if (topology == TOPO_SKLANSKY) begin
      if ((node & span) != 0) return (node / (2 * span)) * (2 * span) + span - 1;
    end else begin
      if (node >= span) return node - span;
    end
    return -1;
  endfunction

endpackage

// File: rtl/prefix_level.sv
// One combinational prefix level: big-circle cells where a partner exists, wires elsewhere.
// Latency: combinational.
// Backpressure: none; stage registering is done by the instantiating adder.
module prefix_level
  import prefix_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int TOPOLOGY = TOPO_KOGGE_STONE,
  parameter int LEVEL    = 0
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_node
    localparam int J = prefix_partner(TOPOLOGY, LEVEL, i);
    if (J >= 0) begin : g_combine
      assign g_o[i] = g_i[i] | (p_i[i] & g_i[J]);
      assign p_o[i] = p_i[i] & p_i[J];
    end else begin : g_pass
      assign g_o[i] = g_i[i];
      assign p_o[i] = p_i[i];
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined parallel-prefix add/subtract with carry, overflow and zero flags plus a sideband tag.
// Latency: NS = ceil(clog2(WIDTH)/STAGE_LEVELS) cycles from accept to out_valid.
// Backpressure: single global advance (out_ready | ~out_valid); all stages freeze together, bubbles kept.
module pipelined_prefix_adder
  import prefix_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STAGE_LEVELS = 2,
  parameter int TOPOLOGY     = TOPO_KOGGE_STONE,
  parameter int TAG_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);

  localparam int L  = clog2(WIDTH);
  localparam int NS = (L + STAGE_LEVELS - 1) / STAGE_LEVELS;

  logic adv;

  // Stage inputs: index 0 is the combinational operand prep, 1..NS-1 are stage registers.
  logic [WIDTH-1:0] st_g   [NS];
  logic [WIDTH-1:0] st_p   [NS];
  logic [WIDTH-1:0] st_p0  [NS];
  logic             st_c   [NS];
  logic             st_vld [NS];
  logic [TAG_W-1:0] st_tag [NS];

  // Per-level inputs and outputs of the prefix network.
  logic [WIDTH-1:0] lvl_gi [L];
  logic [WIDTH-1:0] lvl_pi [L];
  logic [WIDTH-1:0] lvl_go [L];
  logic [WIDTH-1:0] lvl_po [L];

  logic [WIDTH-1:0] b_eff, prep_g, prep_p;
  logic             prep_c;

  logic [WIDTH-1:0] carry, sum_d, sum_q;
  logic             cout_d, ovf_d, zero_d;
  logic             cout_q, ovf_q, zero_q, out_valid_q;
  logic [TAG_W-1:0] tag_q;

  // Whole-word group propagate is not needed by the result.
  logic             unused_grp_p;
  assign unused_grp_p = &{1'b0, lvl_po[L-1]};

  assign adv      = out_ready | ~out_valid_q;
  assign in_ready = adv;

  // Operand conditioning: invert B for subtract, force carry-in, fold carry-in into bit 0.
  always_comb begin
    b_eff     = b ^ {WIDTH{sub}};
    prep_c    = sub | cin;
    prep_p    = a ^ b_eff;
    prep_g    = a & b_eff;
    prep_g[0] = prep_g[0] | (prep_p[0] & prep_c);
  end

  assign st_g[0]   = prep_g;
  assign st_p[0]   = prep_p;
  assign st_p0[0]  = prep_p;
  assign st_c[0]   = prep_c;
  assign st_vld[0] = in_valid;
  assign st_tag[0] = tag_in;

  // Levels that open a group read the stage register; the others chain from the level below.
  for (genvar k = 0; k < L; k++) begin : g_lvl
    if (k % STAGE_LEVELS == 0) begin : g_head
      assign lvl_gi[k] = st_g[k / STAGE_LEVELS];
      assign lvl_pi[k] = st_p[k / STAGE_LEVELS];
    end else begin : g_chain
      assign lvl_gi[k] = lvl_go[k-1];
      assign lvl_pi[k] = lvl_po[k-1];
    end

    prefix_level #(
      .WIDTH    (WIDTH),
      .TOPOLOGY (TOPOLOGY),
      .LEVEL    (k)
    ) u_level (
      .g_i (lvl_gi[k]),
      .p_i (lvl_pi[k]),
      .g_o (lvl_go[k]),
      .p_o (lvl_po[k])
    );
  end

  // Pipeline registers between level groups; the last group feeds the output register.
  for (genvar s = 1; s < NS; s++) begin : g_stage
    localparam int SRC = s * STAGE_LEVELS - 1;

    logic [WIDTH-1:0] g_q, p_q, p0_q;
    logic             c_q, vld_q;
    logic [TAG_W-1:0] stag_q;

    // Whole stage moves on adv (bubbles included) and otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        g_q    <= '0;
        p_q    <= '0;
        p0_q   <= '0;
        c_q    <= 1'b0;
        stag_q <= '0;
      end else if (adv) begin
        vld_q  <= st_vld[s-1];
        g_q    <= lvl_go[SRC];
        p_q    <= lvl_po[SRC];
        p0_q   <= st_p0[s-1];
        c_q    <= st_c[s-1];
        stag_q <= st_tag[s-1];
      end
    end

    assign st_g[s]   = g_q;
    assign st_p[s]   = p_q;
    assign st_p0[s]  = p0_q;
    assign st_c[s]   = c_q;
    assign st_vld[s] = vld_q;
    assign st_tag[s] = stag_q;
  end

  // Sum and flags: final group generates are the carries out of each bit position.
  always_comb begin
    carry  = lvl_go[L-1];
    sum_d  = st_p0[NS-1] ^ {carry[WIDTH-2:0], st_c[NS-1]};
    cout_d = carry[WIDTH-1];
    ovf_d  = carry[WIDTH-1] ^ carry[WIDTH-2];
    zero_d = ~|sum_d;
  end

  // Output register: result and flags stay frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      tag_q       <= '0;
    end else if (adv) begin
      out_valid_q <= st_vld[NS-1];
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      tag_q       <= st_tag[NS-1];
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign tag_out   = tag_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for the pipelined prefix adder: 32-bit Kogge-Stone main DUT plus an 8-bit Sklansky twin.
// Both DUTs have three stages, so they run in lockstep on the same handshake.
// Expected values come from hand tables and an arithmetic (+) reference model.
module tb_pipelined_prefix_adder;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b, sum;
  logic          cin, sub, cout, ovf, zero;
  logic [TW-1:0] tag_in, tag_out;

  logic          in_ready8, out_valid8, cout8, ovf8, zero8;
  logic [7:0]    sum8;
  logic [TW-1:0] tag_out8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipelined_prefix_adder #(.WIDTH(32), .STAGE_LEVELS(2), .TOPOLOGY(0), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero), .tag_out(tag_out)
  );

  pipelined_prefix_adder #(.WIDTH(8), .STAGE_LEVELS(1), .TOPOLOGY(1), .TAG_W(TW)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub), .tag_in(tag_in),
    .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8),
    .cout(cout8), .ovf(ovf8), .zero(zero8), .tag_out(tag_out8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain addition at width w; returns {cout, ovf, zero, sum[63:0]}.
  function automatic logic [66:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input logic ci, input logic is_sub);
    logic [63:0] mask, be, s;
    logic [64:0] full;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    be   = (is_sub ? ~y : y) & mask;
    full = {1'b0, x & mask} + {1'b0, be} + {64'd0, (is_sub | ci)};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (x[w-1] == be[w-1]) && (s[w-1] != x[w-1]);
    return {co, ov, (s == 64'd0), s};
  endfunction

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [3:0]  tag;
  } beat_t;

  beat_t sb[$];

  // Scoreboard: beats pushed on accept, popped and checked on drain, flushed by reset.
  always @(negedge clk) begin : monitor
    beat_t       e;
    logic [66:0] m32, m8;
    if (!rst_n) begin
      sb.delete();
    end else begin
      check("lock_vld", out_valid8, out_valid);
      if (out_valid && out_ready) begin
        check("sb_expect", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e   = sb.pop_front();
          m32 = model(32, {32'h0, e.a}, {32'h0, e.b}, e.cin, e.sub);
          m8  = model(8, {32'h0, e.a}, {32'h0, e.b}, e.cin, e.sub);
          check("sb_sum",   sum,  m32[63:0]);
          check("sb_cout",  cout, m32[66]);
          check("sb_ovf",   ovf,  m32[65]);
          check("sb_zero",  zero, m32[64]);
          check("sb_tag",   tag_out, e.tag);
          check("sb8_sum",  sum8, m8[63:0]);
          check("sb8_cout", cout8, m8[66]);
          check("sb8_ovf",  ovf8, m8[65]);
          check("sb8_zero", zero8, m8[64]);
          check("sb8_tag",  tag_out8, e.tag);
        end
      end
      if (in_valid && in_ready) sb.push_back('{a, b, cin, sub, tag_in});
    end
  end

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [3:0]  tag;
    logic [31:0] s;
    logic        co, ov, z;
  } vec_t;

  vec_t vt[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: accept, measure latency, compare against hand-computed values.
  task automatic run_vec(input vec_t v);
    int lat;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; tag_in = v.tag;
    in_valid = 1'b1; out_ready = 1'b1;
    #2;
    check("vec_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("vec_latency", lat, NS);
    check("vec_sum",  sum,  v.s);
    check("vec_cout", cout, v.co);
    check("vec_ovf",  ovf,  v.ov);
    check("vec_zero", zero, v.z);
    check("vec_tag",  tag_out, v.tag);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          idx, got, stall;
    logic        seen;
    logic [31:0] hold_sum;
    logic [3:0]  hold_tag;
    logic [31:0] edge_vals[4];

    vt[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 4'hA, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h2, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{32'h12345678, 32'h87654321, 1'b1, 1'b0, 4'h3, 32'h9999999A, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 4'h4, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b1, 4'h5, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 4'h6, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 4'h7, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 4'h8, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{32'h00000010, 32'h00000003, 1'b1, 1'b1, 4'h9, 32'h0000000D, 1'b1, 1'b0, 1'b0};
    vt[10] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 4'hB, 32'h00000000, 1'b1, 1'b1, 1'b1};

    // Reset held with a beat offered: nothing may be accepted or produced.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 32'h1234; b = 32'h1; cin = 1'b0; sub = 1'b0; tag_in = 4'h5;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_cout", cout, 0);
    check("rst_zero", zero, 0);
    check("rst_tag", tag_out, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_out_valid", out_valid, 0);

    for (int i = 0; i < 11; i++) run_vec(vt[i]);

    // Backpressure: 8 back-to-back beats, consumer stalls for 5 cycles after the first result.
    idx = 0; got = 0; stall = 0; seen = 1'b0; hold_sum = '0; hold_tag = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = !(seen && stall < 5);
      in_valid = (idx < 8);
      a = idx; b = idx; tag_in = idx[3:0]; cin = 1'b0; sub = 1'b0;
      #2;
      if (!out_ready) begin
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        if (stall == 0) begin
          hold_sum = sum;
          hold_tag = tag_out;
        end else begin
          check("bp_sum_stable", sum, hold_sum);
          check("bp_tag_stable", tag_out, hold_tag);
        end
        stall++;
      end
      if (out_valid) seen = 1'b1;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) got++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_results", got, 8);
    check("bp_stall_cycles", stall, 5);

    // Reset mid-flight: two beats inside the pipe, a third offered while reset is low.
    for (int i = 0; i < 2; i++) begin
      a = 32'h100 + i; b = 32'h7; tag_in = 4'hC + i[3:0]; in_valid = 1'b1;
      tick();
    end
    a = 32'h1FF; rst_n = 1'b0;
    #2;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < NS + 2; i++) begin
      tick();
      check("mid_rst_no_stale", out_valid, 0);
    end
    run_vec(vt[1]);

    // Random handshakes and operands, including carry/sign edge values.
    edge_vals[0] = 32'h00000000; edge_vals[1] = 32'hFFFFFFFF;
    edge_vals[2] = 32'h80000000; edge_vals[3] = 32'h7FFFFFFF;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
      tag_in = $urandom_range(0, 15);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (NS + 2) tick();
    check("drain_empty", sb.size(), 0);
    check("drain_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
